// File: rtl/timer_pkg.sv
// Shared definitions for the timer block family: counter width and the
// drop-counter limits used by the timestamp capture logic.
package timer_pkg;

   localparam int TS_WIDTH       = 32;
   localparam int DROP_CNT_WIDTH = 8;
   localparam logic [DROP_CNT_WIDTH-1:0] DROP_CNT_MAX = 8'd255;

   // Increment that sticks at DROP_CNT_MAX instead of wrapping to zero.
   function automatic logic [DROP_CNT_WIDTH-1:0] sat_inc(input logic [DROP_CNT_WIDTH-1:0] v);
      return (v == DROP_CNT_MAX) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small first-word fall-through FIFO with synchronous reset.
// Full/empty come from the occupancy count so the pointers can wrap freely.
// A push while full is only accepted when a pop frees a slot the same cycle.
module sync_fifo
   import timer_pkg::*;
#(
   parameter int WIDTH = TS_WIDTH,
   parameter int DEPTH = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   level,
   output logic [WIDTH-1:0]         head_data
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_LEVEL = (PTR_W+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   // Qualify requests: never pop an empty FIFO, never overwrite a full one.
   always_comb begin
      empty     = (level == '0);
      full      = (level == FULL_LEVEL);
      do_pop    = pop & ~empty;
      do_push   = push & (~full | do_pop);
      head_data = empty ? '0 : mem[rd_ptr];
   end

   // Storage array; contents are don't-care while empty, so no reset.
   always_ff @(posedge clock) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/timestamp_capture.sv
// Captures the upstream free-running count on each rising edge of an
// asynchronous event line and queues the values in a small FIFO.
// Events arriving while the FIFO is full are dropped and tallied.
module timestamp_capture
   import timer_pkg::*;
#(
   parameter int WIDTH       = TS_WIDTH,
   parameter int DEPTH       = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [WIDTH-1:0]           count_in,
   input  logic                       event_in,
   input  logic                       clear_ovf,
   output logic                       ts_valid,
   input  logic                       ts_ready,
   output logic [WIDTH-1:0]           ts_data,
   output logic                       ts_ovf,
   output logic [DROP_CNT_WIDTH-1:0]  drop_cnt,
   output logic [$clog2(DEPTH):0]     level
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev;
   logic                   ev;
   logic                   pop;
   logic                   drop;
   logic                   fifo_empty;
   logic                   fifo_full;

   // Metastability chain for event_in plus one flop of edge history.
   // Clearing prev on reset means a line already high at release still
   // produces exactly one capture once it reaches the end of the chain.
   always_ff @(posedge clock) begin
      if (reset) begin
         sync_q <= '0;
         prev   <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], event_in};
         prev   <= sync_q[SYNC_STAGES-1];
      end
   end

   // Rising-edge pulse, handshake, and drop decision. A full FIFO still
   // takes the new entry if the consumer frees a slot on the same edge.
   always_comb begin
      ev       = sync_q[SYNC_STAGES-1] & ~prev;
      ts_valid = ~fifo_empty;
      pop      = ts_valid & ts_ready;
      drop     = ev & fifo_full & ~pop;
   end

   sync_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (ev),
      .push_data (count_in),
      .pop       (pop),
      .empty     (fifo_empty),
      .full      (fifo_full),
      .level     (level),
      .head_data (ts_data)
   );

   // Sticky overflow flag and saturating drop tally. A drop on the same
   // edge as a clear wins, leaving the tally at one.
   always_ff @(posedge clock) begin
      if (reset) begin
         ts_ovf   <= 1'b0;
         drop_cnt <= '0;
      end else if (drop) begin
         ts_ovf   <= 1'b1;
         drop_cnt <= clear_ovf ? DROP_CNT_WIDTH'(1) : sat_inc(drop_cnt);
      end else if (clear_ovf) begin
         ts_ovf   <= 1'b0;
         drop_cnt <= '0;
      end
   end

endmodule

// File: tb/tb_timestamp_capture.sv
// Directed bench for timestamp_capture. A loadable free-running counter
// drives count_in; inputs change and outputs are sampled on the falling edge.
module tb_timestamp_capture;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] count_in;
   logic        event_in;
   logic        clear_ovf;
   logic        ts_valid;
   logic        ts_ready;
   logic [31:0] ts_data;
   logic        ts_ovf;
   logic [7:0]  drop_cnt;
   logic [2:0]  level;

   logic        cnt_load;
   logic [31:0] cnt_load_val;

   int compared   = 0;
   int mismatched = 0;

   timestamp_capture #(
      .WIDTH       (32),
      .DEPTH       (4),
      .SYNC_STAGES (2)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .count_in  (count_in),
      .event_in  (event_in),
      .clear_ovf (clear_ovf),
      .ts_valid  (ts_valid),
      .ts_ready  (ts_ready),
      .ts_data   (ts_data),
      .ts_ovf    (ts_ovf),
      .drop_cnt  (drop_cnt),
      .level     (level)
   );

   // Free-running clock.
   always #5 clock = ~clock;

   // Stand-in for the upstream counter, loadable to reach interesting values.
   always @(posedge clock) begin
      if (cnt_load) count_in <= cnt_load_val;
      else          count_in <= count_in + 32'd1;
   end

   task automatic tick();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic set_count(input logic [31:0] v);
      cnt_load     = 1'b1;
      cnt_load_val = v;
      tick();
      cnt_load     = 1'b0;
   endtask

   // Leave the bench at the falling edge just before count_in==v is sampled.
   task automatic wait_count(input logic [31:0] v);
      int n = 0;
      while (count_in !== v && n < 2000) begin
         tick();
         n++;
      end
      if (count_in !== v) begin
         compared++;
         mismatched++;
         $display("[TB] FAIL wait_count: count_in=%0d never reached %0d", count_in, v);
      end
   endtask

   // One clean event pulse: two cycles high, two cycles low.
   task automatic applyStimulus();
      event_in = 1'b1;
      tick();
      tick();
      event_in = 1'b0;
      tick();
      tick();
   endtask

   // Event at count v held for three cycles.
   task automatic event_at(input logic [31:0] v);
      wait_count(v);
      event_in = 1'b1;
      tick();
      tick();
      tick();
      event_in = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] c;
      reset    = 1'b1;
      event_in = 1'b1;
      tick();
      tick();
      tick();
      compared += 5;
      if (ts_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_valid: got %0b want 0", ts_valid); end
      if (ts_data !== 32'd0) begin mismatched++; $display("[TB] FAIL rst_data: got %0d want 0", ts_data); end
      if (level !== 3'd0)    begin mismatched++; $display("[TB] FAIL rst_level: got %0d want 0", level); end
      if (ts_ovf !== 1'b0)   begin mismatched++; $display("[TB] FAIL rst_ovf: got %0b want 0", ts_ovf); end
      if (drop_cnt !== 8'd0) begin mismatched++; $display("[TB] FAIL rst_drop: got %0d want 0", drop_cnt); end
      reset = 1'b0;
      c = count_in;
      tick();
      tick();
      compared++;
      if (ts_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL rel_early_valid: got %0b want 0", ts_valid); end
      tick();
      compared += 3;
      if (ts_valid !== 1'b1)    begin mismatched++; $display("[TB] FAIL rel_valid: got %0b want 1", ts_valid); end
      if (ts_data !== c + 32'd2) begin mismatched++; $display("[TB] FAIL rel_data: got %0d want %0d", ts_data, c + 32'd2); end
      if (level !== 3'd1)       begin mismatched++; $display("[TB] FAIL rel_level: got %0d want 1", level); end
      tick();
      tick();
      tick();
      compared += 2;
      if (level !== 3'd1)    begin mismatched++; $display("[TB] FAIL held_level: got %0d want 1", level); end
      if (drop_cnt !== 8'd0) begin mismatched++; $display("[TB] FAIL held_drop: got %0d want 0", drop_cnt); end
      event_in = 1'b0;
      ts_ready = 1'b1;
      tick();
      ts_ready = 1'b0;
      compared++;
      if (ts_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL rel_drain: got %0b want 0", ts_valid); end
   endtask

   task automatic test_basic_capture();
      set_count(32'd90);
      ts_ready = 1'b1;
      wait_count(32'd100);
      event_in = 1'b1;
      tick();
      tick();
      tick();
      event_in = 1'b0;
      compared += 2;
      if (ts_valid !== 1'b1)  begin mismatched++; $display("[TB] FAIL basic_valid: got %0b want 1", ts_valid); end
      if (ts_data !== 32'd102) begin mismatched++; $display("[TB] FAIL basic_data: got %0d want 102", ts_data); end
      tick();
      compared += 2;
      if (ts_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL basic_valid_low: got %0b want 0", ts_valid); end
      if (level !== 3'd0)    begin mismatched++; $display("[TB] FAIL basic_level: got %0d want 0", level); end
      ts_ready = 1'b0;
   endtask

   task automatic test_overflow_drain();
      logic [31:0] exp_q [4];
      exp_q = '{32'd12, 32'd22, 32'd32, 32'd42};
      set_count(32'd5);
      for (int i = 1; i <= 6; i++) event_at(32'(i * 10));
      tick();
      tick();
      compared += 3;
      if (level !== 3'd4)    begin mismatched++; $display("[TB] FAIL ovf_level: got %0d want 4", level); end
      if (ts_ovf !== 1'b1)   begin mismatched++; $display("[TB] FAIL ovf_flag: got %0b want 1", ts_ovf); end
      if (drop_cnt !== 8'd2) begin mismatched++; $display("[TB] FAIL ovf_drop: got %0d want 2", drop_cnt); end
      for (int i = 0; i < 4; i++) begin
         compared += 2;
         if (ts_valid !== 1'b1)     begin mismatched++; $display("[TB] FAIL drain_valid[%0d]: got %0b want 1", i, ts_valid); end
         if (ts_data !== exp_q[i])  begin mismatched++; $display("[TB] FAIL drain_data[%0d]: got %0d want %0d", i, ts_data, exp_q[i]); end
         tick();
         compared += 2;
         if (ts_valid !== 1'b1)     begin mismatched++; $display("[TB] FAIL stall_valid[%0d]: got %0b want 1", i, ts_valid); end
         if (ts_data !== exp_q[i])  begin mismatched++; $display("[TB] FAIL stall_data[%0d]: got %0d want %0d", i, ts_data, exp_q[i]); end
         ts_ready = 1'b1;
         tick();
         ts_ready = 1'b0;
      end
      compared += 2;
      if (ts_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL drained_valid: got %0b want 0", ts_valid); end
      if (ts_ovf !== 1'b1)   begin mismatched++; $display("[TB] FAIL drained_ovf: got %0b want 1", ts_ovf); end
   endtask

   task automatic test_full_with_pop();
      logic [31:0] exp_q [4];
      exp_q = '{32'd212, 32'd222, 32'd232, 32'd242};
      set_count(32'd195);
      for (int i = 0; i < 4; i++) event_at(32'(200 + i * 10));
      wait_count(32'd240);
      event_in = 1'b1;
      tick();
      tick();
      ts_ready = 1'b1;
      tick();
      ts_ready = 1'b0;
      event_in = 1'b0;
      compared += 3;
      if (level !== 3'd4)     begin mismatched++; $display("[TB] FAIL fullpop_level: got %0d want 4", level); end
      if (drop_cnt !== 8'd2)  begin mismatched++; $display("[TB] FAIL fullpop_drop: got %0d want 2", drop_cnt); end
      if (ts_data !== 32'd212) begin mismatched++; $display("[TB] FAIL fullpop_head: got %0d want 212", ts_data); end
      ts_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         compared++;
         if (ts_data !== exp_q[i]) begin mismatched++; $display("[TB] FAIL fullpop_order[%0d]: got %0d want %0d", i, ts_data, exp_q[i]); end
         tick();
      end
      ts_ready = 1'b0;
      compared++;
      if (level !== 3'd0) begin mismatched++; $display("[TB] FAIL fullpop_empty: got %0d want 0", level); end
   endtask

   task automatic test_clear_and_saturate();
      clear_ovf = 1'b1;
      tick();
      clear_ovf = 1'b0;
      compared += 2;
      if (ts_ovf !== 1'b0)   begin mismatched++; $display("[TB] FAIL clr1_ovf: got %0b want 0", ts_ovf); end
      if (drop_cnt !== 8'd0) begin mismatched++; $display("[TB] FAIL clr1_drop: got %0d want 0", drop_cnt); end
      for (int i = 0; i < 4 + 255; i++) applyStimulus();
      compared += 3;
      if (level !== 3'd4)      begin mismatched++; $display("[TB] FAIL sat_level: got %0d want 4", level); end
      if (drop_cnt !== 8'd255) begin mismatched++; $display("[TB] FAIL sat_255: got %0d want 255", drop_cnt); end
      if (ts_ovf !== 1'b1)     begin mismatched++; $display("[TB] FAIL sat_ovf: got %0b want 1", ts_ovf); end
      applyStimulus();
      compared++;
      if (drop_cnt !== 8'd255) begin mismatched++; $display("[TB] FAIL sat_hold: got %0d want 255", drop_cnt); end
      event_in = 1'b1;
      tick();
      tick();
      clear_ovf = 1'b1;
      tick();
      clear_ovf = 1'b0;
      event_in  = 1'b0;
      compared += 2;
      if (ts_ovf !== 1'b1)   begin mismatched++; $display("[TB] FAIL clrdrop_ovf: got %0b want 1", ts_ovf); end
      if (drop_cnt !== 8'd1) begin mismatched++; $display("[TB] FAIL clrdrop_cnt: got %0d want 1", drop_cnt); end
      tick();
      clear_ovf = 1'b1;
      tick();
      clear_ovf = 1'b0;
      compared += 2;
      if (ts_ovf !== 1'b0)   begin mismatched++; $display("[TB] FAIL clr2_ovf: got %0b want 0", ts_ovf); end
      if (drop_cnt !== 8'd0) begin mismatched++; $display("[TB] FAIL clr2_drop: got %0d want 0", drop_cnt); end
   endtask

   task automatic test_reset_mid();
      event_in = 1'b1;
      tick();
      event_in = 1'b0;
      reset    = 1'b1;
      tick();
      reset = 1'b0;
      compared += 2;
      if (level !== 3'd0)    begin mismatched++; $display("[TB] FAIL mid_level: got %0d want 0", level); end
      if (ts_data !== 32'd0) begin mismatched++; $display("[TB] FAIL mid_data: got %0d want 0", ts_data); end
      for (int i = 0; i < 4; i++) tick();
      compared++;
      if (ts_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_cancel: got %0b want 0", ts_valid); end
   endtask

   task automatic test_wrap();
      set_count(32'hFFFF_FFF0);
      event_at(32'hFFFF_FFFF);
      compared += 2;
      if (ts_valid !== 1'b1)          begin mismatched++; $display("[TB] FAIL wrap_valid: got %0b want 1", ts_valid); end
      if (ts_data !== 32'h0000_0001)  begin mismatched++; $display("[TB] FAIL wrap_data: got %08h want 00000001", ts_data); end
      ts_ready = 1'b1;
      tick();
      ts_ready = 1'b0;
   endtask

   initial begin
      reset        = 1'b1;
      event_in     = 1'b0;
      clear_ovf    = 1'b0;
      ts_ready     = 1'b0;
      cnt_load     = 1'b1;
      cnt_load_val = 32'd0;
      @(negedge clock);
      cnt_load = 1'b0;
      test_reset();
      test_basic_capture();
      test_overflow_drain();
      test_full_with_pop();
      test_clear_and_saturate();
      test_reset_mid();
      test_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   // Hard stop in case a task stalls unexpectedly.
   initial begin
      #500000;
      $display("[TB] FAIL timeout: simulation did not finish, compared=%0d", compared);
      $fatal(1, "[TB] timeout");
   end

endmodule

// File: doc/timestamp_capture.md
Name: timestamp_capture

Overview:
- Downstream consumer of the 32-bit free-running synchronous counter.
- Detects rising edges on an external event line and captures the counter value at each edge as a timestamp.
- Buffers timestamps in a small FIFO with a valid/ready output interface.
- Keeps a sticky overflow flag and a saturating drop counter for events lost while the FIFO is full.

Parameters:
- WIDTH, 32, width of count_in and ts_data.
- DEPTH, 4, FIFO entries; must be a power of 2 and at least 2.
- SYNC_STAGES, 2, synchronizer flops on event_in; must be at least 2.

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- count_in  input  WIDTH  free-running count from the upstream counter.
- event_in  input  1  asynchronous event line; a rising edge triggers a capture.
- clear_ovf  input  1  one-cycle pulse; clears ts_ovf and drop_cnt.
- ts_valid  output  1  FIFO non-empty; ts_data is meaningful.
- ts_ready  input  1  consumer accepts the head entry when ts_valid is also high.
- ts_data  output  WIDTH  oldest captured timestamp (first-word fall-through).
- ts_ovf  output  1  sticky flag: at least one event dropped.
- drop_cnt  output  8  number of dropped events; saturates at 255.
- level  output  $clog2(DEPTH)+1  number of entries currently in the FIFO (0..DEPTH).

Behaviour:
- Reset clears sync flops, edge-history flop, FIFO pointers, level, ts_ovf and drop_cnt.
  - After reset: ts_valid=0, ts_data=0, level=0, ts_ovf=0, drop_cnt=0.
  - FIFO storage contents need not be cleared, but ts_data must read 0 while the FIFO is empty.
- Synchronizer: event_in passes through SYNC_STAGES flops (s1..sN); flop prev holds the previous sN.
- Edge pulse: ev = sN & ~prev.
- Timing: if event_in is first sampled high at edge E0, ev is high in the cycle before edge E0+SYNC_STAGES.
- Push: occurs at edge E0+SYNC_STAGES and stores count_in as sampled at that edge.
  - With count_in driven by the free-running counter, stored value = (count sampled at E0) + SYNC_STAGES.
  - Counter wrap (0xFFFFFFFF to 0) needs no special handling; the value is stored verbatim.
- Event rate: one capture per rising edge.
  - event_in held high produces exactly one capture.
  - Pulses shorter than one clock may be missed; this is acceptable.
- Pop: occurs at a rising edge when ts_valid & ts_ready.
  - Head advances and level decrements.
  - ts_data and ts_valid must stay stable while ts_valid & ~ts_ready.
- Push into an empty FIFO: no combinational bypass; ts_valid rises the cycle after the push edge.
- Push and pop in the same cycle, not full: both happen; level unchanged; order preserved.
- Push while full (level==DEPTH):
  - Without a pop the same cycle: new timestamp discarded, ts_ovf set to 1, drop_cnt increments (saturating at 255).
  - With a pop the same cycle: push accepted, no drop, level stays DEPTH.
- Pop while empty: impossible, since ts_valid=0.
- clear_ovf:
  - Clears ts_ovf and drop_cnt at the next edge.
  - If a drop occurs the same cycle, the drop wins: ts_ovf=1, drop_cnt=1.
- Reset mid-operation:
  - All queued timestamps are lost.
  - A capture in flight through the synchronizer is cancelled.
  - If event_in is high at reset release, exactly one capture occurs SYNC_STAGES edges after release, since prev resets to 0.
- Pointers: $clog2(DEPTH) bits, wrapping naturally. Full/empty derived from level.

Decomposition:
- Shared package (timer_pkg):
  - TS_WIDTH = 32, the counter width shared with the upstream counter.
  - DROP_CNT_WIDTH = 8.
  - DROP_CNT_MAX = 255.
- Sub-module sync_fifo (params WIDTH, DEPTH):
  - Inputs: push, push_data, pop.
  - Outputs: empty, full, level, head_data.
  - Behaviour: first-word fall-through, synchronous reset.
- Top level holds the synchronizer, edge detect, and overflow/drop logic.

Test Plan:
- Reset held 3 cycles with event_in=1, then released -> exactly one entry; ts_valid rises 3 cycles after release; level=1; drop_cnt=0.
- Counter running; event_in rises when count sampled = 100; ts_ready=1 -> ts_data=102 with ts_valid high for 1 cycle; level returns to 0.
- ts_ready=0; 6 separate events at counts 10, 20, 30, 40, 50, 60 (each 3 cycles high) -> level=4, entries 12, 22, 32, 42; ts_ovf=1; drop_cnt=2. Then drain: outputs 12, 22, 32, 42 in order, with data stable while stalled.
- FIFO full with ts_ready=1 in the same cycle as a push -> no drop; level stays 4; drop_cnt unchanged.
- drop_cnt at 255 plus another drop -> stays 255. clear_ovf coinciding with a drop -> ts_ovf=1, drop_cnt=1. clear_ovf alone -> both 0.
- Count near wrap: event sampled at count 0xFFFFFFFF -> ts_data=0x00000001.
